// File: rtl/pattern_source_pkg.sv
// Shared definitions for the pattern source: FSM states, payload mode
// encodings, frame constants and the payload/LFSR helper functions.
// Ports: none (package).
package pattern_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  localparam logic [7:0]  HDR_MAGIC  = 8'hA5;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] CONST_WORD = 32'hDEAD_BEEF;

  // Right-shifting Galois LFSR: the polynomial is folded in whenever the
  // bit shifted out is a one.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  // Payload word for index idx; lfsr is the LFSR value belonging to idx.
  function automatic logic [31:0] payload_word(input mode_t mode,
                                               input logic [15:0] idx,
                                               input logic [31:0] lfsr);
    logic [31:0] w;
    case (mode)
      MODE_COUNT: w = {16'd0, idx};
      MODE_WALK:  w = 32'd1 << idx[4:0];
      MODE_LFSR:  w = lfsr;
      default:    w = CONST_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a debouncer for a raw push-button level.
// Ports: clk_in/rst_in (async active-high), raw_in (asynchronous level),
//        clean_out (level that only moves after DEBOUNCE_CYCLES equal samples).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_in,
  output logic clean_out
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      // cnt_q counts consecutive synchronized samples that disagree with the
      // clean level; any agreeing sample restarts the count.
      if (sync2_q == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        clean_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign clean_out = clean_q;

endmodule

// File: rtl/pattern_source.sv
// Push-button triggered frame generator feeding the data gateway:
// header {A5, seq, len}, len payload words in the selected pattern, and a
// 32-bit sum trailer, sent with valid/ready handshaking.
// Ports: clk_in, rst_in (async active-high), trigger_in (raw button),
//        mode_in/len_in (sampled at frame start), ready_in (gateway not-full),
//        data_out/valid_out (frame word), busy_out (frame in progress).
module pattern_source
  import pattern_source_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter logic [31:0] LFSR_SEED       = 32'h0000_0001
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trigger_in,
  input  logic [1:0]  mode_in,
  input  logic [15:0] len_in,
  input  logic        ready_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy_out
);

  logic        clean;
  logic        clean_prev_q;
  logic        start;
  logic        xfer;
  logic        last_payload;

  state_t      state_q;
  mode_t       mode_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [7:0]  seq_q;
  logic [31:0] lfsr_q;
  logic [31:0] sum_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        busy_q;

  logic [31:0] lfsr_d;
  logic [31:0] sum_d;
  logic [15:0] idx_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .raw_in   (trigger_in),
    .clean_out(clean)
  );

  // Edges seen outside IDLE never reach the FSM, so presses while busy are
  // dropped rather than queued.
  assign start        = (state_q == ST_IDLE) && clean && !clean_prev_q;
  assign xfer         = valid_q && ready_in;
  assign lfsr_d       = lfsr_step(lfsr_q);
  assign sum_d        = sum_q + data_q;
  assign idx_d        = idx_q + 16'd1;
  assign last_payload = (idx_q == len_q - 16'd1);

  // idx_q/lfsr_q always describe the payload word currently on data_q, so
  // the next word is built from their advanced values on each transfer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clean_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      mode_q       <= MODE_COUNT;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      seq_q        <= 8'd0;
      lfsr_q       <= LFSR_SEED;
      sum_q        <= 32'd0;
      data_q       <= 32'd0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clean_prev_q <= clean;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode_t'(mode_in);
            len_q   <= len_in;
            idx_q   <= 16'd0;
            lfsr_q  <= LFSR_SEED;
            sum_q   <= 32'd0;
            data_q  <= {HDR_MAGIC, seq_q, len_in};
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (xfer) begin
            if (len_q == 16'd0) begin
              data_q  <= 32'd0;
              state_q <= ST_TRAILER;
            end else begin
              data_q  <= payload_word(mode_q, 16'd0, lfsr_q);
              state_q <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            sum_q  <= sum_d;
            lfsr_q <= lfsr_d;
            idx_q  <= idx_d;
            if (last_payload) begin
              data_q  <= sum_d;
              state_q <= ST_TRAILER;
            end else begin
              data_q <= payload_word(mode_q, idx_d, lfsr_d);
            end
          end
        end
        ST_TRAILER: begin
          if (xfer) begin
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            seq_q   <= seq_q + 8'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  // busy covers the start cycle itself, before the registered flag rises.
  assign busy_out  = busy_q | start;

endmodule

// File: tb/tb_pattern_source.sv
module tb_pattern_source;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        trigger_in;
  logic [1:0]  mode_in;
  logic [15:0] len_in;
  logic        ready_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy_out;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  seq_model = 8'd0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          stall_vis = 0;

  pattern_source #(
    .DEBOUNCE_CYCLES(4),
    .LFSR_SEED      (32'h0000_0001)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .trigger_in(trigger_in),
    .mode_in   (mode_in),
    .len_in    (len_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy_out  (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, len payload words from the pattern rules, sum.
  task automatic build_expected(input logic [1:0] m, input logic [15:0] len, input logic [7:0] seq);
    logic [31:0] sum, l, w;
    exp_q.delete();
    exp_q.push_back({8'hA5, seq, len});
    sum = 32'd0;
    l   = 32'h1;
    for (int i = 0; i < int'(len); i++) begin
      case (m)
        2'd0: w = 32'(i);
        2'd1: w = 32'd1 << (i % 32);
        2'd2: begin
          w = l;
          l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
        default: w = 32'hDEAD_BEEF;
      endcase
      sum = sum + w;
      exp_q.push_back(w);
    end
    exp_q.push_back(sum);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low for 3 cycles
  // while word stall_idx is presented. repress: drop and re-raise the
  // button while the frame is running.
  task automatic run_frame(input int mode, input int len, input int rmode,
                           input int stall_idx, input bit repress);
    int n, got, cyc, budget, first_cyc, last_cyc, cur_vis, stall_left;
    bit prev_stall, r, saw;
    logic [31:0] prev_data;
    logic [1:0]  m;
    logic [15:0] l16;
    m   = 2'(mode);
    l16 = 16'(len);
    build_expected(m, l16, seq_model);
    obs_q.delete();
    n = exp_q.size();
    got = 0; cyc = 0; first_cyc = -1; last_cyc = -1; cur_vis = 0; stall_left = 3;
    prev_stall = 1'b0; prev_data = 32'd0;
    budget = 40 + 5 * n;
    mode_in = m; len_in = l16; trigger_in = 1'b1; ready_in = 1'b0;
    while (got < n && cyc < budget) begin
      @(negedge clk_in);
      cyc++;
      if (prev_stall) begin
        check("hold_vld", {31'd0, valid_out}, 32'd1);
        check("hold_dat", data_out, prev_data);
      end
      if (valid_out) begin
        check("busy_with_vld", {31'd0, busy_out}, 32'd1);
        if (first_cyc < 0) first_cyc = cyc;
        cur_vis++;
      end
      case (rmode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          if (valid_out && got == stall_idx && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end else begin
            r = 1'b1;
          end
        end
      endcase
      ready_in = r;
      if (valid_out && r) begin
        check("word", data_out, exp_q[got]);
        obs_q.push_back(data_out);
        if (got == stall_idx) stall_vis = cur_vis;
        cur_vis = 0;
        got++;
        last_cyc = cyc;
      end
      prev_stall = valid_out && !r;
      prev_data  = data_out;
      if (got > 0) begin
        mode_in = 2'($urandom);
        len_in  = 16'($urandom);
      end
      if (repress && first_cyc >= 0)
        trigger_in = ((cyc - first_cyc) < 8) ? 1'b0 : 1'b1;
    end
    if (got < n) check("frame_timeout", 32'(got), 32'(n));
    if (rmode == 0 && got == n) check("no_gaps", 32'(last_cyc - first_cyc + 1), 32'(n));
    @(negedge clk_in);
    check("end_vld", {31'd0, valid_out}, 32'd0);
    check("end_busy", {31'd0, busy_out}, 32'd0);
    seq_model = seq_model + 8'd1;
    trigger_in = 1'b0;
    ready_in = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      if (valid_out || busy_out) saw = 1'b1;
    end
    check("idle_after", {31'd0, saw}, 32'd0);
  endtask

  initial begin
    logic [31:0] want5[5];
    logic [31:0] tmp;
    bit          saw;
    int          cnt;

    rst_in = 1'b1; trigger_in = 1'b0; mode_in = 2'd0; len_in = 16'd0; ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_vld", {31'd0, valid_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_dat", data_out, 32'd0);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // counter mode, len 3, ready always high
    run_frame(0, 3, 0, 0, 1'b0);
    want5 = '{32'hA500_0003, 32'd0, 32'd1, 32'd2, 32'd3};
    for (int i = 0; i < 5; i++) check("cnt_frame", obs_q[i], want5[i]);

    // constant mode with a 3-cycle stall on the first payload word
    run_frame(3, 2, 2, 1, 1'b0);
    check("const_p0", obs_q[1], 32'hDEAD_BEEF);
    check("const_trl", obs_q[3], 32'hBD5B_7DDE);
    check("stall_vis", 32'(stall_vis), 32'd4);

    // LFSR mode, len 2
    run_frame(2, 2, 0, 0, 1'b0);
    check("lfsr_p0", obs_q[1], 32'h0000_0001);
    check("lfsr_p1", obs_q[2], 32'h8020_0003);
    check("lfsr_trl", obs_q[3], 32'h8020_0004);

    // zero-length frame skips the payload
    run_frame(1, 0, 0, 0, 1'b0);
    check("len0_words", 32'(obs_q.size()), 32'd2);
    tmp = obs_q[0];
    check("len0_hdr", {tmp[31:24], tmp[15:0]}, 32'h00A5_0000);
    check("len0_trl", obs_q[1], 32'd0);

    // 3-cycle glitch must not start a frame
    trigger_in = 1'b1;
    repeat (3) @(negedge clk_in);
    trigger_in = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk_in);
      if (valid_out || busy_out) saw = 1'b1;
    end
    check("glitch", {31'd0, saw}, 32'd0);

    // second press while busy is ignored (idle_after inside run_frame)
    run_frame(0, 30, 0, 0, 1'b1);

    // randomized frames
    for (int k = 0; k < 12; k++)
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 1, 0, 1'b0);

    // reset in the middle of the payload
    mode_in = 2'd0; len_in = 16'd10; trigger_in = 1'b1; ready_in = 1'b1;
    cnt = 0;
    while (!valid_out && cnt < 40) begin
      @(negedge clk_in);
      cnt++;
    end
    check("mid_hdr_seen", {31'd0, valid_out}, 32'd1);
    repeat (4) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, valid_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_out}, 32'd0);
    check("mid_rst_dat", data_out, 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rel_vld", {31'd0, valid_out}, 32'd0);
    check("rel_busy", {31'd0, busy_out}, 32'd0);
    trigger_in = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk_in);
      if (valid_out || busy_out) saw = 1'b1;
    end
    check("rel_no_frame", {31'd0, saw}, 32'd0);
    seq_model = 8'd0;
    run_frame(1, 4, 1, 0, 1'b0);
    tmp = obs_q[0];
    check("post_rst_hdr", {16'd0, tmp[31:16]}, 32'h0000_A500);

    // 256 frames since reset bring seq back to 0
    while (seq_model != 8'd0) run_frame(3, 0, 0, 0, 1'b0);
    run_frame(0, 1, 0, 0, 1'b0);
    tmp = obs_q[0];
    check("seq_wrap", {24'd0, tmp[23:16]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
